// File: rtl/mul_iter_unit.sv
// Iterative 32x32 multiplier for MUL / UMULL / SMULL requests.
// A radix-2 shift-add engine runs one multiplier bit per cycle.
// SMULL works on magnitudes, and the final product is negated when the
// operand signs differ.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results and flags hold their last values
// CALC  | one shift-add iteration per cycle, WIDTH iterations in total
// DONE  | one-cycle done pulse; a new legal start is accepted here too
module mul_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MUL   = 3'b100;
   localparam logic [2:0] OP_UMULL = 3'b101;
   localparam logic [2:0] OP_SMULL = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_n;
   logic [2:0]         op_q;
   logic               neg_sign;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;

   logic               legal, accept, reject, last_iter;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_step, prod;
   logic [WIDTH-1:0]   fin_lo, fin_hi;
   logic [3:0]         fin_flags;

   // Request decode: a start is only considered outside CALC.
   always_comb begin
      legal     = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
      accept    = start && (state != CALC) && legal;
      reject    = start && (state != CALC) && !legal;
      last_iter = (state == CALC) && (count == LAST);
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = CALC;
         CALC:    if (count == LAST) state_n = DONE;
         DONE:    state_n = accept ? CALC : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Operand magnitudes, one shift-add step, and the final signed/truncated result.
   always_comb begin
      a_abs    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
      b_abs    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_step = {sum, acc[WIDTH-1:1]};
      prod     = neg_sign ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
      fin_lo   = prod[WIDTH-1:0];
      fin_hi   = (op_q == OP_MUL) ? '0 : prod[2*WIDTH-1:WIDTH];
      fin_flags = {((op_q == OP_MUL) ? fin_lo[WIDTH-1] : fin_hi[WIDTH-1]),
                   ({fin_hi, fin_lo} == '0), 2'b00};
   end

   // Datapath, handshake and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         flags     <= 4'b0000;
         op_q      <= 3'b000;
         neg_sign  <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
      end else begin
         busy    <= (state_n == CALC);
         done    <= last_iter;
         illegal <= reject;
         if (accept) begin
            op_q <= op;
            if (op == OP_SMULL) begin
               mcand    <= a_abs;
               mplier   <= b_abs;
               neg_sign <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
               mcand    <= a;
               mplier   <= b;
               neg_sign <= 1'b0;
            end
            acc   <= '0;
            count <= '0;
         end else if (state == CALC) begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == LAST) begin
               result_lo <= fin_lo;
               result_hi <= fin_hi;
               flags     <= fin_flags;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Scoreboard bench for mul_iter_unit: the driver pushes the arithmetic
// reference result and its due cycle; the monitor pops on every done/illegal.
module tb_mul_iter_unit;

   localparam logic [2:0] MUL   = 3'b100;
   localparam logic [2:0] UMULL = 3'b101;
   localparam logic [2:0] SMULL = 3'b110;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, illegal;
   logic [31:0] result_lo, result_hi;
   logic [3:0]  flags;

   mul_iter_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .flags(flags), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [3:0]  fl;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   ill_q[$];
   exp_t mon_e;
   int   compared = 0;
   int   mismatched = 0;
   logic [31:0] last_lo = '0, last_hi = '0;
   logic [3:0]  last_fl = '0;

   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] p;
      longint      sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == SMULL)      p = 64'(sx * sy);
      else if (o == UMULL) p = {32'b0, x} * {32'b0, y};
      else                 p = {32'b0, 32'(x * y)};
      e.lo  = p[31:0];
      e.hi  = (o == MUL) ? 32'b0 : p[63:32];
      e.fl  = {((o == MUL) ? e.lo[31] : e.hi[31]), ({e.hi, e.lo} == 64'b0), 2'b00};
      e.due = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: compare every done and illegal pulse against the queued expectations.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (done === 1'b1) begin
            chk("busy_with_done", {63'b0, busy}, 64'd0);
            if (sb.size() == 0) fail_now("unexpected_done");
            else begin
               mon_e = sb.pop_front();
               chk("result_lo", {32'b0, result_lo}, {32'b0, mon_e.lo});
               chk("result_hi", {32'b0, result_hi}, {32'b0, mon_e.hi});
               chk("flags", {60'b0, flags}, {60'b0, mon_e.fl});
               chk("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
         end
         if (illegal === 1'b1) begin
            if (ill_q.size() == 0) fail_now("unexpected_illegal");
            else chk("illegal_cycle", 64'(cyc), 64'(ill_q.pop_front()));
         end
      end
   end

   // Drive one request at a negedge once busy is low; expectations are queued here.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int   g;
      exp_t e;
      g = 0;
      while (busy && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) fail_now("busy_timeout");
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (o == MUL || o == UMULL || o == SMULL) begin
         e       = model(o, x, y);
         e.due   = cyc + 33;
         last_lo = e.lo;
         last_hi = e.hi;
         last_fl = e.fl;
         sb.push_back(e);
      end else begin
         ill_q.push_back(cyc + 1);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((sb.size() != 0 || ill_q.size() != 0) && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         fail_now("drain_timeout");
         sb.delete();
         ill_q.delete();
      end
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (!done && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) fail_now("done_timeout");
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [2:0] ops [3];
      ops[0] = MUL;
      ops[1] = UMULL;
      ops[2] = SMULL;
      reset = 1'b0;
      start = 1'b0;
      op    = 3'b000;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_outs", {result_hi, result_lo}, 64'd0);
      chk("reset_flags", {59'b0, flags, done}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases.
      issue(UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();
      issue(SMULL, 32'hFFFF_FFFE, 32'h0000_0003);
      wait_done();
      issue(SMULL, 32'h8000_0000, 32'h8000_0000);
      wait_done();
      issue(MUL, 32'h0001_0000, 32'h0001_0000);
      drain();
      issue(MUL, 32'd7, 32'd6);
      drain();
      @(negedge clk);

      // Starts while busy (legal and illegal) must be dropped silently.
      issue(UMULL, 32'd3, 32'd5);
      repeat (8) @(negedge clk);
      start = 1'b1; op = SMULL; a = 32'd9; b = 32'd9;
      @(negedge clk);
      op = 3'b011;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (40) @(negedge clk);

      // Illegal op in IDLE.
      issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
      chk("illegal_busy", {63'b0, busy}, 64'd0);
      chk("illegal_hold", {result_hi, result_lo}, {last_hi, last_lo});
      chk("illegal_flags", {60'b0, flags}, {60'b0, last_fl});
      @(negedge clk);
      chk("illegal_pulse_len", {63'b0, illegal}, 64'd0);
      drain();

      // Randomized traffic, mixing back-to-back and idle gaps.
      for (int i = 0; i < 24; i++) begin
         issue(ops[$urandom_range(0, 2)], pick_operand(), pick_operand());
         if ($urandom_range(0, 1) == 1) wait_done();
         else begin
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      drain();
      @(negedge clk);

      // Reset in the middle of CALC aborts with no done pulse.
      issue(UMULL, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (14) @(negedge clk);
      reset = 1'b0;
      #1;
      sb.delete();
      chk("abort_busy_done", {62'b0, busy, done}, 64'd0);
      chk("abort_results", {result_hi, result_lo}, 64'd0);
      chk("abort_flags", {59'b0, flags, illegal}, 64'd0);
      last_lo = '0; last_hi = '0; last_fl = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      issue(MUL, 32'd7, 32'd6);
      drain();
      @(negedge clk);

      chk("queues_empty", 64'(sb.size() + ill_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mul_iter_unit.md
# mul_iter_unit

Iterative 32x32 multiply responder for the multicycle ARM core. The controller issues MUL, UMULL and SMULL requests using its ALUControl encoding. This block accepts each request with a start/busy/done handshake and computes the product with a radix-2 shift-add engine. It returns a 32-bit result (MUL) or a 64-bit result split into hi/lo words (UMULL/SMULL), together with NZCV flags, for the datapath's 64-bit write-back path.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH; the counter is sized for WIDTH iterations
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- start  in  1  request strobe, sampled on rising edge; accepted only when busy=0
- op  in  3  ALUControl code: 3'b100 MUL, 3'b101 UMULL, 3'b110 SMULL; every other code is illegal
- a  in  WIDTH  multiplicand (Rn), sampled with an accepted start
- b  in  WIDTH  multiplier (Rm), sampled with an accepted start
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse; result and flags are valid in that cycle
- result_lo  out  WIDTH  low product word
- result_hi  out  WIDTH  high product word; forced 0 for MUL
- flags  out  4  {N,Z,C,V} of the completed operation
- illegal  out  1  one-cycle pulse when start is seen in IDLE/DONE with an illegal op

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values (reset=0, asynchronous): busy=0, done=0, illegal=0, result_lo=0, result_hi=0, flags=4'b0000, iteration counter=0, accumulator=0.
- IDLE or DONE, start=1, op legal, on an edge:
  - latch op
  - for SMULL: store |a| and |b| and neg_sign=a[31]^b[31]
  - for MUL/UMULL: store a, b unsigned and neg_sign=0
  - clear the 2*WIDTH accumulator, set count=0, go to CALC
- IDLE or DONE, start=1, op illegal: pulse illegal, stay in or enter IDLE, leave results and flags unchanged.
- CALC, each edge:
  - if multiplier[0]=1, add multiplicand into the accumulator's upper half (WIDTH+1-bit add including carry-out)
  - shift accumulator and multiplier right by 1; count++
  - after iteration WIDTH-1 (count wraps to 0), go to DONE
- DONE entry edge:
  - if neg_sign, register the two's-complement negation of the 64-bit product
  - MUL registers only the low word; result_hi=0
- Flags:
  - N = result_hi[31] for UMULL/SMULL, result_lo[31] for MUL
  - Z = 1 iff all result bits of the operation are zero (64 bits for long ops, 32 for MUL)
  - C = 0 and V = 0 always
- DONE lasts one cycle, then goes to IDLE unless a new start is accepted (back-to-back).
- result_lo, result_hi and flags hold their values until the next DONE or reset.
- start while busy=1 is ignored with no side effects, including when op is illegal (no illegal pulse).
- |0x80000000| is represented as the unsigned value 0x80000000, which makes SMULL INT_MIN*INT_MIN correct.

## Timing
- Start accepted at edge E0 → busy=1 from E0 through E32. CALC occupies E1..E32. DONE is entered at E32, so done=1 in the cycle after E32.
- Latency: done arrives 33 cycles after the cycle in which start was sampled. Throughput: one operation per 33 cycles with a back-to-back start in the DONE cycle.
- busy and done are never high together.
- illegal pulses in the cycle after the offending start edge.
- Reset asserted during CALC aborts the operation immediately. No done pulse follows. All outputs return to reset values, and the first legal start after reset deassertion behaves normally.
- Outputs are registered only; no combinational path from start, op, a or b to any output.

## Test plan
- UMULL a=0xFFFFFFFF, b=0xFFFFFFFF → done 33 cycles after start, result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=4'b1000.
- SMULL a=0xFFFFFFFE (-2), b=3 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, N=1. SMULL 0x80000000*0x80000000 → result_hi=0x40000000, result_lo=0, flags=0.
- MUL a=0x00010000, b=0x00010000 → result_lo=0, result_hi=0, flags=4'b0100. MUL 7*6 → result_lo=42, result_hi=0.
- Start UMULL 3*5, then pulse start with SMULL 9*9 at cycle 10 while busy → single done with lo=15; second request dropped, no illegal pulse.
- Back-to-back: second start in the DONE cycle → second done exactly 33 cycles later, with no idle gap.
- op=3'b011 with start in IDLE → illegal pulse for one cycle, busy stays 0, prior results unchanged. Reset low at cycle 15 of a UMULL → all outputs 0, no done pulse.
